// File: rtl/instruction_fetch.sv
// Fetch-side initiator: owns the PC, issues sequential word requests to imem under a
// credit limit, and queues returned words with their PC in a small prefetch FIFO for decode.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_data,
    output logic [31:0] inst_pc
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW:0]   DEPTH_C = (CW + 1)'(DEPTH);
    localparam logic [CW-1:0] ONE_C   = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   rsp_pc_q, rsp_pc_d;
    logic [CW-1:0] live_q, live_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_q, wr_d;
    logic [AW-1:0] rd_q, rd_d;

    logic [31:0] pc_mem   [DEPTH];
    logic [31:0] data_mem [DEPTH];

    logic [CW:0] inflight;
    logic        req_fire;
    logic        rsp_drop;
    logic        push;
    logic        pop;
    logic        unused_ok;

    assign unused_ok = ^redirect_pc[1:0];

    // FIFO entries plus every outstanding request share one budget, so a push can never overflow.
    assign inflight       = {1'b0, count_q} + {1'b0, live_q} + {1'b0, drop_q};
    assign imem_req_valid = rst_n && !redirect_valid && (inflight < DEPTH_C);
    assign imem_addr      = fetch_pc_q;
    assign inst_valid     = (count_q != '0) && !redirect_valid;
    assign inst_data      = data_mem[rd_q];
    assign inst_pc        = pc_mem[rd_q];

    assign req_fire = imem_req_valid && imem_req_ready;
    assign rsp_drop = !redirect_valid && imem_rsp_valid && (drop_q != '0);
    assign push     = !redirect_valid && imem_rsp_valid && (drop_q == '0) && (live_q != '0);
    assign pop      = inst_valid && inst_ready;

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rsp_pc_d   = rsp_pc_q;
        live_d     = live_q;
        drop_d     = drop_q;
        count_d    = count_q;
        wr_d       = wr_q;
        rd_d       = rd_q;
        if (redirect_valid) begin
            fetch_pc_d = {redirect_pc[31:2], 2'b00};
            rsp_pc_d   = {redirect_pc[31:2], 2'b00};
            count_d    = '0;
            wr_d       = rd_q;
            live_d     = '0;
            if (imem_rsp_valid && ((live_q != '0) || (drop_q != '0))) begin
                drop_d = drop_q + live_q - ONE_C;
            end else begin
                drop_d = drop_q + live_q;
            end
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (rsp_drop) begin
                drop_d = drop_q - ONE_C;
            end
            if (push) begin
                rsp_pc_d = rsp_pc_q + 32'd4;
                wr_d     = wr_q + PTR_ONE;
            end
            if (pop) begin
                rd_d = rd_q + PTR_ONE;
            end
            live_d  = live_q + CW'(req_fire) - CW'(push);
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= RESET_PC;
            rsp_pc_q   <= RESET_PC;
            live_q     <= '0;
            drop_q     <= '0;
            count_q    <= '0;
            wr_q       <= '0;
            rd_q       <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rsp_pc_q   <= rsp_pc_d;
            live_q     <= live_d;
            drop_q     <= drop_d;
            count_q    <= count_d;
            wr_q       <= wr_d;
            rd_q       <= rd_d;
        end
    end

    // Storage needs no reset: count gates everything read from it.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_q]   <= rsp_pc_q;
            data_mem[wr_q] <= imem_rsp_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: queue-based reference model checked every cycle, a fixed-latency
// memory model, directed phases, and a second instance exercising the PC wrap from FFFF_FFF8.
module tb_instruction_fetch;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid, inst_ready;
    logic [31:0] inst_data, inst_pc;

    logic        b_req_valid, b_req_ready;
    logic [31:0] b_addr;
    logic        b_rsp_valid;
    logic [31:0] b_rsp_data;
    logic        b_redirect_valid;
    logic [31:0] b_redirect_pc;
    logic        b_inst_valid, b_inst_ready;
    logic [31:0] b_inst_data, b_inst_pc;

    instruction_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_data(inst_data), .inst_pc(inst_pc)
    );

    instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(DEPTH)) dut_wrap (
        .clk(clk), .rst_n(rst_n),
        .imem_req_valid(b_req_valid), .imem_req_ready(b_req_ready), .imem_addr(b_addr),
        .imem_rsp_valid(b_rsp_valid), .imem_rsp_data(b_rsp_data),
        .redirect_valid(b_redirect_valid), .redirect_pc(b_redirect_pc),
        .inst_valid(b_inst_valid), .inst_ready(b_inst_ready), .inst_data(b_inst_data), .inst_pc(b_inst_pc)
    );

    typedef struct { logic [31:0] pc; bit killed; } req_t;
    typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;
    typedef struct { int due; logic [31:0] addr; } mem_t;

    int n_checks = 0;
    int n_errs   = 0;
    int cyc      = 0;
    int lat      = 1;
    int first_req_cyc = -1;
    int first_val_cyc = -1;

    req_t        m_out[$];
    ent_t        m_fifo[$];
    logic [31:0] m_fetch_pc;
    mem_t        memq[$];
    ent_t        pop_log[$];
    logic [31:0] b_req_log[$];
    ent_t        b_pop_log[$];
    bit          b_pend;
    logic [31:0] b_pend_addr;
    logic        rst_n_next;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] log_pc(int i);
        if (i < pop_log.size()) return pop_log[i].pc;
        return 'x;
    endfunction

    function automatic logic [31:0] log_data(int i);
        if (i < pop_log.size()) return pop_log[i].data;
        return 'x;
    endfunction

    // Called on the falling edge: compare, record, then advance the model past the next rising edge.
    task automatic model_step();
        bit   e_req;
        bit   e_iv;
        req_t r;
        e_req = rst_n && !redirect_valid && (m_fifo.size() + m_out.size() < DEPTH);
        e_iv  = rst_n && !redirect_valid && (m_fifo.size() > 0);
        chk("req_valid", 32'(imem_req_valid), 32'(e_req));
        chk("imem_addr", imem_addr, m_fetch_pc);
        chk("inst_valid", 32'(inst_valid), 32'(e_iv));
        if (e_iv) begin
            chk("inst_pc", inst_pc, m_fifo[0].pc);
            chk("inst_data", inst_data, m_fifo[0].data);
        end
        if (rst_n) begin
            if (inst_valid && first_val_cyc < 0) first_val_cyc = cyc;
            if (inst_valid && inst_ready) pop_log.push_back('{inst_pc, inst_data});
            if (imem_req_valid && imem_req_ready) begin
                if (first_req_cyc < 0) first_req_cyc = cyc;
                memq.push_back('{cyc + lat, imem_addr});
            end
            if (b_req_valid && b_req_ready) begin
                b_pend      = 1'b1;
                b_pend_addr = b_addr;
                b_req_log.push_back(b_addr);
            end
            if (b_inst_valid && b_inst_ready) b_pop_log.push_back('{b_inst_pc, b_inst_data});

            if (redirect_valid) begin
                m_fetch_pc = {redirect_pc[31:2], 2'b00};
                foreach (m_out[i]) m_out[i].killed = 1'b1;
                if (imem_rsp_valid && m_out.size() > 0) void'(m_out.pop_front());
                m_fifo.delete();
            end else begin
                if (e_iv && inst_ready) void'(m_fifo.pop_front());
                if (imem_rsp_valid && m_out.size() > 0) begin
                    r = m_out.pop_front();
                    if (!r.killed) m_fifo.push_back('{r.pc, r.pc >> 2});
                end
                if (e_req && imem_req_ready) begin
                    m_out.push_back('{m_fetch_pc, 1'b0});
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic cycle(input bit rr, input bit ir, input bit rv, input logic [31:0] rpc);
        @(posedge clk);
        cyc++;
        #1;
        rst_n          = rst_n_next;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if (memq.size() > 0 && memq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = memq[0].addr >> 2;
            void'(memq.pop_front());
        end
        b_rsp_valid    = b_pend;
        b_rsp_data     = b_pend_addr >> 2;
        b_pend         = 1'b0;
        imem_req_ready = rr;
        inst_ready     = ir;
        redirect_valid = rv;
        redirect_pc    = rpc;
        @(negedge clk);
        model_step();
    endtask

    task automatic mid_reset();
        @(posedge clk);
        cyc++;
        #1;
        rst_n          = 1'b0;
        rst_n_next     = 1'b0;
        imem_rsp_valid = 1'b0;
        b_rsp_valid    = 1'b0;
        redirect_valid = 1'b0;
        #1;
        chk("midrst inst_valid", 32'(inst_valid), 32'd0);
        chk("midrst req_valid", 32'(imem_req_valid), 32'd0);
        chk("midrst imem_addr", imem_addr, 32'h0);
        m_out.delete();
        m_fifo.delete();
        m_fetch_pc = 32'h0;
        memq.delete();
        b_pend = 1'b0;
        @(negedge clk);
        model_step();
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int m;
        rst_n            = 1'b0;
        rst_n_next       = 1'b0;
        imem_req_ready   = 1'b0;
        imem_rsp_valid   = 1'b0;
        imem_rsp_data    = '0;
        redirect_valid   = 1'b0;
        redirect_pc      = '0;
        inst_ready       = 1'b0;
        b_req_ready      = 1'b1;
        b_rsp_valid      = 1'b0;
        b_rsp_data       = '0;
        b_redirect_valid = 1'b0;
        b_redirect_pc    = '0;
        b_inst_ready     = 1'b1;
        b_pend           = 1'b0;
        b_pend_addr      = '0;
        m_fetch_pc       = 32'h0;

        @(negedge clk);
        model_step();
        chk("reset req_valid", 32'(imem_req_valid), 32'd0);
        chk("reset addr", imem_addr, 32'h0);
        chk("reset wrap addr", b_addr, 32'hFFFF_FFF8);
        cycle(1, 1, 0, 0);

        // streaming with a 1-cycle memory
        rst_n_next = 1'b1;
        cycle(1, 1, 0, 0);
        chk("first req addr", imem_addr, 32'h0);
        repeat (13) cycle(1, 1, 0, 0);
        chk("first valid latency", 32'(first_val_cyc - first_req_cyc), 32'd2);
        for (int i = 0; i < 10; i++) begin
            chk("stream pc", log_pc(i), 32'(4 * i));
            chk("stream data", log_data(i), 32'(i));
        end

        // decode stall fills the FIFO and throttles requests
        repeat (10) cycle(1, 0, 0, 0);
        chk("full req_valid", 32'(imem_req_valid), 32'd0);
        chk("full inst_valid", 32'(inst_valid), 32'd1);
        m = pop_log.size();
        repeat (6) cycle(1, 1, 0, 0);
        for (int i = 0; i < 4; i++) chk("release pc", log_pc(m + i), 32'h30 + 32'(4 * i));

        // memory back-pressure holds the address
        cycle(0, 1, 1, 32'h10);
        repeat (5) begin
            cycle(0, 1, 0, 0);
            chk("stall addr", imem_addr, 32'h10);
            chk("stall req_valid", 32'(imem_req_valid), 32'd1);
        end
        cycle(1, 1, 0, 0);
        cycle(0, 1, 0, 0);
        chk("after accept addr", imem_addr, 32'h14);

        // 3-cycle memory, redirect with two requests in flight
        for (int k = 0; k < 8 && memq.size() > 0; k++) cycle(0, 1, 0, 0);
        repeat (2) cycle(0, 1, 0, 0);
        lat = 3;
        cycle(0, 1, 1, 32'h20);
        cycle(1, 1, 0, 0);
        cycle(1, 1, 0, 0);
        cycle(0, 1, 1, 32'h103);
        chk("redirect held addr", imem_addr, 32'h28);
        m = pop_log.size();
        cycle(1, 1, 0, 0);
        chk("post-redirect addr", imem_addr, 32'h100);
        repeat (12) cycle(1, 1, 0, 0);
        chk("redirect pc0", log_pc(m), 32'h100);
        chk("redirect pc1", log_pc(m + 1), 32'h104);
        chk("redirect data0", log_data(m), 32'h40);

        // asynchronous reset with two entries queued and one request outstanding
        repeat (4) cycle(0, 1, 0, 0);
        lat = 1;
        cycle(0, 0, 1, 32'h40);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        cycle(1, 0, 0, 0);
        chk("pre-reset inst_valid", 32'(inst_valid), 32'd1);
        mid_reset();
        cycle(1, 1, 0, 0);
        rst_n_next = 1'b1;
        cycle(1, 1, 0, 0);
        chk("restart addr", imem_addr, 32'h0);
        chk("restart req_valid", 32'(imem_req_valid), 32'd1);
        m = pop_log.size();
        repeat (6) cycle(1, 1, 0, 0);
        chk("restart pc0", log_pc(m), 32'h0);
        chk("restart pc1", log_pc(m + 1), 32'h4);

        // wrapping instance
        for (int i = 0; i < 4; i++) begin
            logic [31:0] exp_pc;
            exp_pc = 32'hFFFF_FFF8 + 32'(4 * i);
            chk("wrap req", (i < b_req_log.size()) ? b_req_log[i] : 'x, exp_pc);
            chk("wrap pc", (i < b_pop_log.size()) ? b_pop_log[i].pc : 'x, exp_pc);
            chk("wrap data", (i < b_pop_log.size()) ? b_pop_log[i].data : 'x, exp_pc >> 2);
        end

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
